// File: rtl/score_ram_sequencer.sv
// Score-matrix RAM sequencer for the NW datapath: writes the gap boundary, then walks
// every inner cell issuing diag/left/up reads, a calculator start, and the score write-back.
module score_ram_sequencer #(
  parameter int N   = 4,
  parameter int GAP = 1,
  parameter int AW  = 5,
  parameter int IW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [8:0]    ram_wdata,
  output logic          om_en_read,
  output logic [1:0]    om_count,
  output logic          calc_start,
  input  logic          calc_done,
  input  logic [8:0]    calc_score,
  output logic [IW-1:0] cur_i,
  output logic [IW-1:0] cur_j
);

  localparam int ROW = N + 1;
  localparam int CW  = (AW > 3) ? AW : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_READ, S_DRAIN, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [8:0]    score_q, score_d;

  logic [31:0]   kf, ri, cj;
  logic [8:0]    mag;

  assign kf = 32'(cnt_q);
  assign ri = 32'(i_q);
  assign cj = 32'(j_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      score_q <= score_d;
    end
  end

  // cnt_q is the boundary index in INIT and the cell phase c0..c6 afterwards
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    score_d = score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_INIT: begin
        if (cnt_q == CW'(2 * N)) begin
          state_d = S_READ;
          cnt_d   = '0;
          i_d     = IW'(1);
          j_d     = IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(4)) state_d = S_CALC;
      end
      S_CALC: begin
        if (calc_done) begin
          score_d = calc_score;
          state_d = S_WRITE;
        end else begin
          // parking past phase 5 keeps calc_start to the first CALC cycle
          cnt_d = CW'(6);
        end
      end
      S_WRITE: begin
        cnt_d = '0;
        if (i_q == IW'(N) && j_q == IW'(N)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          if (j_q == IW'(N)) begin
            j_d = IW'(1);
            i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    om_en_read = 1'b0;
    om_count   = '0;
    calc_start = 1'b0;
    mag        = '0;
    case (state_q)
      S_INIT: begin
        busy   = 1'b1;
        ram_we = 1'b1;
        if (kf <= N) begin
          ram_addr = AW'(kf);
          mag      = 9'(kf * GAP);
        end else begin
          ram_addr = AW'((kf - N) * ROW);
          mag      = 9'((kf - N) * GAP);
        end
        ram_wdata = -mag;
      end
      S_READ: begin
        busy = 1'b1;
        case (cnt_q)
          CW'(0):  ram_addr = AW'((ri - 1) * ROW + cj - 1);
          CW'(1):  ram_addr = AW'(ri * ROW + cj - 1);
          default: ram_addr = AW'((ri - 1) * ROW + cj);
        endcase
        // read data returns one cycle later, so the manager index trails the address
        if (cnt_q != '0) begin
          om_en_read = 1'b1;
          om_count   = 2'(cnt_q - CW'(1));
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CW'(3)) begin
          om_en_read = 1'b1;
          om_count   = 2'd2;
        end
      end
      S_CALC: begin
        busy       = 1'b1;
        calc_start = (cnt_q == CW'(5));
      end
      S_WRITE: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = AW'(ri * ROW + cj);
        ram_wdata = score_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign cur_i = i_q;
  assign cur_j = j_q;

endmodule

// File: tb/tb_score_ram_sequencer.sv
// Scoreboard bench for score_ram_sequencer: a planner queues expected RAM writes,
// output-manager reads, calculator starts and done pulses; a negedge monitor checks them.
module tb_score_ram_sequencer;

  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int IW  = 3;
  localparam int ROW = N + 1;
  localparam int NC  = N * N;

  logic          clk = 1'b0;
  logic          rst, start, calc_done;
  logic [8:0]    calc_score;
  logic          busy, done, ram_we, om_en_read, calc_start;
  logic [AW-1:0] ram_addr;
  logic [8:0]    ram_wdata;
  logic [1:0]    om_count;
  logic [IW-1:0] cur_i, cur_j;
  logic          busy2, done2, ram_we2, om_en_read2, calc_start2;
  logic [AW-1:0] ram_addr2;
  logic [8:0]    ram_wdata2;
  logic [1:0]    om_count2;
  logic [IW-1:0] cur_i2, cur_j2;

  score_ram_sequencer #(.N(N), .GAP(1), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .om_en_read(om_en_read), .om_count(om_count), .calc_start(calc_start),
    .calc_done(calc_done), .calc_score(calc_score), .cur_i(cur_i), .cur_j(cur_j)
  );

  score_ram_sequencer #(.N(N), .GAP(2), .AW(AW), .IW(IW)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
    .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2),
    .om_en_read(om_en_read2), .om_count(om_count2), .calc_start(calc_start2),
    .calc_done(calc_done), .calc_score(calc_score), .cur_i(cur_i2), .cur_j(cur_j2)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int a; int b; } ev_t;
  typedef ev_t evq_t[$];

  evq_t wr_q, rd_q, cs_q, dn_q, w2_q;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int done_rel = 0;
  int abort_rel = 0;

  logic       drv_done [256];
  logic [8:0] drv_score[256];
  logic       drv_start[256];

  int         init_addr[9] = '{0, 1, 2, 3, 4, 5, 10, 15, 20};
  int         init_d1[9]   = '{'h000, 'h1FF, 'h1FE, 'h1FD, 'h1FC, 'h1FF, 'h1FE, 'h1FD, 'h1FC};
  int         init_d2[9]   = '{'h000, 'h1FE, 'h1FC, 'h1FA, 'h1F8, 'h1FE, 'h1FC, 'h1FA, 'h1F8};
  logic [8:0] scr[NC] = '{9'h003, 9'h1FE, 9'h005, 9'h000, 9'h1F0, 9'h07F, 9'h100, 9'h0FF,
                          9'h002, 9'h1FF, 9'h010, 9'h011, 9'h1AB, 9'h055, 9'h0C3, 9'h12E};
  int         dly[NC] = '{0, 4, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm, input int rel);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d, required none", nm, rel);
  endtask

  task automatic purge_one(input string nm, input evq_t q, input int lim);
    foreach (q[k]) begin
      if (q[k].cyc < lim) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: event for cycle %0d never seen, required present", nm, q[k].cyc);
      end
    end
  endtask

  task automatic purge_all(input int lim);
    purge_one("wr_missing", wr_q, lim);
    purge_one("rd_missing", rd_q, lim);
    purge_one("cs_missing", cs_q, lim);
    purge_one("dn_missing", dn_q, lim);
    purge_one("w2_missing", w2_q, lim);
    wr_q.delete(); rd_q.delete(); cs_q.delete(); dn_q.delete(); w2_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_addr"}, int'(ram_addr), 0);
    chk({tag, "_we"}, int'(ram_we), 0);
    chk({tag, "_wdata"}, int'(ram_wdata), 0);
    chk({tag, "_en_read"}, int'(om_en_read), 0);
    chk({tag, "_count"}, int'(om_count), 0);
    chk({tag, "_calc_start"}, int'(calc_start), 0);
    chk({tag, "_cur_i"}, int'(cur_i), 0);
    chk({tag, "_cur_j"}, int'(cur_j), 0);
  endtask

  // Builds the whole cycle schedule of one fill relative to start acceptance.
  task automatic plan(input bit with_delays, input bit with_gap2);
    int b, i, j, d;
    for (int r = 0; r < 256; r++) begin
      drv_done[r] = 1'b0; drv_score[r] = '0; drv_start[r] = 1'b0;
    end
    for (int k = 0; k < 9; k++) begin
      wr_q.push_back('{k, init_addr[k], init_d1[k]});
      if (with_gap2) w2_q.push_back('{k, init_addr[k], init_d2[k]});
    end
    b = 9;
    for (int k = 0; k < NC; k++) begin
      i = k / N + 1;
      j = k % N + 1;
      d = with_delays ? dly[k] : 0;
      rd_q.push_back('{b + 1, 0, (i - 1) * ROW + j - 1});
      rd_q.push_back('{b + 2, 1, i * ROW + j - 1});
      rd_q.push_back('{b + 3, 2, (i - 1) * ROW + j});
      cs_q.push_back('{b + 5, i, j});
      drv_done[b + 5 + d]  = 1'b1;
      drv_score[b + 5 + d] = scr[k];
      wr_q.push_back('{b + 6 + d, i * ROW + j, int'(scr[k])});
      if (with_delays && k == 2) begin
        drv_done[b + 1]  = 1'b1;
        drv_score[b + 1] = 9'h0AA;
      end
      if (with_delays && k == 3) drv_start[b + 2] = 1'b1;
      if (k == 6) abort_rel = b;
      b = b + 7 + d;
    end
    if (with_delays) drv_start[3] = 1'b1;
    dn_q.push_back('{b, 0, 0});
    done_rel = b;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic play(input int ncyc, input int abort_at);
    for (int r = 0; r < ncyc; r++) begin
      if (r == abort_at) begin
        rst = 1'b1;
        calc_done = 1'b0;
        start = 1'b0;
        #1;
        chk_zero("abort");
        purge_all(r);
        return;
      end
      calc_done  = drv_done[r];
      calc_score = drv_score[r];
      start      = drv_start[r];
      @(posedge clk);
      #1;
    end
    calc_done = 1'b0;
    start     = 1'b0;
  endtask

  initial begin : monitor
    int   rel;
    int   prev_addr;
    ev_t  e;
    prev_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rel = cyc - t0;
        if (ram_we) begin
          if (wr_q.size() == 0) unexp("wr", rel);
          else begin
            e = wr_q.pop_front();
            chk("wr_cycle", rel, e.cyc);
            chk("wr_addr", int'(ram_addr), e.a);
            chk("wr_data", int'(ram_wdata), e.b);
          end
        end
        if (om_en_read) begin
          if (rd_q.size() == 0) unexp("om_read", rel);
          else begin
            e = rd_q.pop_front();
            chk("rd_cycle", rel, e.cyc);
            chk("rd_count", int'(om_count), e.a);
            chk("rd_addr", prev_addr, e.b);
          end
        end
        if (calc_start) begin
          if (cs_q.size() == 0) unexp("calc_start", rel);
          else begin
            e = cs_q.pop_front();
            chk("cs_cycle", rel, e.cyc);
            chk("cs_cur_i", int'(cur_i), e.a);
            chk("cs_cur_j", int'(cur_j), e.b);
          end
        end
        if (done) begin
          if (dn_q.size() == 0) unexp("done", rel);
          else begin
            e = dn_q.pop_front();
            chk("done_cycle", rel, e.cyc);
            chk("busy_at_done", int'(busy), 0);
          end
        end
        if (ram_we2 && w2_q.size() != 0) begin
          e = w2_q.pop_front();
          chk("gap2_cycle", rel, e.cyc);
          chk("gap2_addr", int'(ram_addr2), e.a);
          chk("gap2_data", int'(ram_wdata2), e.b);
        end
      end
      prev_addr = int'(ram_addr);
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    calc_done  = 1'b0;
    calc_score = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill with delayed calculator, spurious calc_done and ignored starts
    plan(1'b1, 1'b1);
    launch();
    play(done_rel + 3, -1);
    chk("hold_cur_i", int'(cur_i), N);
    chk("hold_cur_j", int'(cur_j), N);
    chk("idle_busy", int'(busy), 0);
    purge_all(1 << 30);

    // reset during READ of cell (2,3)
    plan(1'b0, 1'b0);
    launch();
    play(done_rel + 3, abort_rel);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_abort_busy", int'(busy), 0);
    chk("post_abort_we", int'(ram_we), 0);

    // clean rerun, back-to-back 7-cycle cells
    plan(1'b0, 1'b0);
    launch();
    play(done_rel + 3, -1);
    purge_all(1 << 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_ram_sequencer.md
Name: score_ram_sequencer

Overview:
Master controller for the score-matrix RAM in the NW datapath. It first writes the gap-penalty boundary (row 0, column 0). It then walks every inner cell (i,j) in row-major order. For each cell it issues the diag/left/up reads and drives en_read/count of the output manager. It then starts the cell calculator and writes the returned score back to RAM. Sits between the top-level FSM (start/done) and the score RAM, output manager and score calculator.

Parameters:
N, 4, sequence length; matrix is (N+1)x(N+1), row-major, addr = i*(N+1)+j
GAP, 1, positive gap penalty magnitude; boundary cell k holds -k*GAP
AW, 5, RAM address width; must satisfy 2^AW >= (N+1)^2
IW, 3, index width; must satisfy 2^IW > N

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run a full matrix fill
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last cell has been written
ram_addr  out  AW  score RAM address (read or write)
ram_we  out  1  score RAM write enable
ram_wdata  out  9  score RAM write data, two's complement
om_en_read  out  1  output manager en_read
om_count  out  2  output manager buffer index
calc_start  out  1  one-cycle pulse: diag/left/up outputs are valid this cycle
calc_done  in  1  calculator result valid
calc_score  in  9  calculator result, two's complement
cur_i  out  IW  current row index (1..N during fill)
cur_j  out  IW  current column index (1..N during fill)

Behaviour:
- Reset values: busy=0, done=0, ram_addr=0, ram_we=0, ram_wdata=0, om_en_read=0, om_count=0, calc_start=0, cur_i=0, cur_j=0; FSM goes to IDLE. Reset mid-operation aborts immediately. No partial write completes after rst rises.
- States: IDLE, INIT, READ, DRAIN, CALC, WRITE, DONE.
- IDLE: start=1 -> INIT, busy=1 next cycle. start while busy is ignored.
- INIT: writes 2N+1 consecutive cycles with ram_we=1.
  - Order: addr 0 = 0; then row 0, j=1..N, value -j*GAP; then column 0, i=1..N, addr i*(N+1), value -i*GAP.
  - Values are truncated to 9 bits (two's complement). Parameterisation must keep N*GAP <= 256.
  - After the last write -> READ with cur_i=1, cur_j=1.
- READ, 3 cycles c0..c2, ram_we=0. ram_addr is in order:
  - diag = (i-1)*(N+1)+(j-1)
  - left = i*(N+1)+(j-1)
  - up = (i-1)*(N+1)+j
- RAM read latency is 1. om_en_read=1 with om_count=0,1,2 in cycles c1,c2,c3, aligned with the returned data.
- DRAIN: covers c3 (last en_read) and c4 (output manager internal ready). om_en_read=0 from c4.
- CALC: entered at c5. calc_start=1 in c5 only. The state holds until calc_done=1; calc_done may already be 1 in c5. calc_done outside CALC is ignored.
- WRITE: one cycle after the done cycle. ram_we=1, ram_addr = i*(N+1)+j, ram_wdata = calc_score captured on calc_done.
- Index advance in the WRITE cycle: j<N -> j+1; else j=1, i+1. The next READ c0 follows WRITE immediately.
- Cell throughput: 7 cycles when calc_done arrives in c5.
- WRITE of cell (N,N) -> DONE. DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE. cur_i/cur_j hold their last values until the next start.
- Outside INIT and WRITE, ram_we=0 and ram_wdata=0.

Test Plan:
- Reset, then start, N=4, GAP=1 -> 9 write cycles.
  - Addrs 0,1,2,3,4,5,10,15,20.
  - Data 0,-1(9'h1FF),-2,-3,-4,-1,-2,-3,-4.
- Cell (1,1), calc_done in c5 with score 9'h003:
  - ram_addr 0,5,1 in c0..c2.
  - om_en_read with count 0,1,2 in c1..c3.
  - calc_start in c5.
  - Write addr 6, data 3 in c6.
  - Next cell (1,2) reads 1,6,2 starting c7.
- calc_done delayed 4 cycles after calc_start -> FSM holds CALC, no RAM activity, then a single write. calc_done pulsed during READ -> ignored.
- Full run, N=4 -> 16 inner writes; last write addr 24; done pulse in the following cycle; busy low from that cycle; total 9+16*7+1 cycles from start acceptance.
- start pulsed mid-fill -> no restart, sequence unaffected.
- rst asserted during READ of cell (2,3) -> all outputs 0 immediately, FSM idle. A new start re-runs INIT from addr 0.
- GAP=2, N=4 -> boundary value at addr 20 is -8 = 9'h1F8.
